sha3_block_padder: RTL and testbench
====================================

# sha3_block_padder

Sequential message padder for the SHA3-512 low-area core. It accepts the message as a stream of 32-bit big-endian words and assembles 576-bit rate blocks (18 words). On the final word it applies SHA3 padding: the domain byte 0x06 after the last message byte and 0x80 in the last byte of the block. It sits between the host input interface and the Keccak-f permutation stage, which consumes each block through a ready/ack handshake. Final-word byte placement uses the team's existing combinational word padder.

## Interface
- No parameters. Rate fixed at 576 bits = 18 words.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in` input 32: message word; byte 0 in `in[31:24]`.
- `in_ready` input 1: `in` is valid this cycle.
- `is_last` input 1: qualifies `in_ready`; this word is the final (possibly partial) word.
- `byte_num` input 2: valid bytes in the final word, 0..3, used only with `is_last`. 0 means the word carries no message bytes.
- `buffer_full` output 1: block buffer holds 18 words; upstream must hold its word.
- `out` output 576: assembled block; the first accepted word is at `out[575:544]`, the 18th at `out[31:0]`.
- `out_ready` output 1: `out` is a complete block. Equals `buffer_full`.
- `f_ack` input 1: permutation stage has taken `out`; frees the buffer.

## Operation
- **Word counter `cnt` (0..18).** `buffer_full = (cnt == 18)`. On each word write, `out` shifts left by 32 and the new word enters `out[31:0]`.
- **State ACCEPT** (after reset):
  - A word is accepted when `in_ready && !buffer_full`.
  - Non-last word: written unchanged; `cnt` increments.
  - Last word: written as the padded word. Keep the first `byte_num` bytes of `in`, then 0x06, then zeros.
    - If `byte_num` = 0, the word is 0x06000000.
    - If this is slot 17 (`cnt` == 17), OR in 0x00000080.
    - Move to PAD, or straight to DONE when slot 17 was just written.
- **State PAD.**
  - Each cycle with `!buffer_full`, write a zero word, or 0x00000080 when writing slot 17. `in_ready` is ignored.
  - When slot 17 is written, move to DONE.
- **State DONE.**
  - No writes. `in_ready` is ignored until reset.
  - The final block stays presented until `f_ack`, after which `buffer_full` and `out_ready` are 0.
- **`f_ack`.**
  - When `f_ack && buffer_full`: `cnt` goes to 0 on the next edge. `out` contents are not cleared.
  - `f_ack` while not full is ignored.
  - A word presented in the ack cycle is not accepted, because `buffer_full` is still 1.
- **Reset.** `reset_n` low at any time, including mid-block or mid-PAD:
  - Immediately sets `cnt` = 0, state = ACCEPT, `out` = 0.
  - The partial block is discarded.
- **Reset values:** `out` = 0, `out_ready` = 0, `buffer_full` = 0.

## Timing
- One word is written per cycle at most. There is no combinational path from `in` to `out`.
- `buffer_full` and `out_ready` rise on the clock edge that writes slot 17. They are visible the same cycle as the completed `out`.
- `buffer_full` falls on the edge after `f_ack` is sampled high. Upstream may present a new word that same following cycle.
- PAD fills one zero word per cycle. If the last word lands in slot k (k < 17), `out_ready` asserts 17 − k cycles after the edge that accepted the last word.
- `in_ready` and `f_ack` may be held high continuously. Throughput is 18 words per block, plus 1 ack cycle.

## Test plan
- **Empty message.** Reset, then `in_ready=1`, `is_last=1`, `byte_num=0`.
  - After 18 cycles `out_ready`=1.
  - `out[575:544]`=0x06000000, words 1..16 = 0, `out[31:0]`=0x00000080.
  - After `f_ack`, `out_ready` stays 0 and further `in_ready` is ignored.
- **Last word in slot 17.** 17 words 0xAAAAAAAA, then `in`=0x11223344, `is_last=1`, `byte_num=3`.
  - `out[31:0]`=0x11223386 and state is DONE with no pad block.
  - After `f_ack`, no second block appears.
- **Exact block multiple.** 18 non-last words produce `out_ready`; hold `f_ack` 1 cycle.
  - Then `is_last=1`, `byte_num=0`: the second block is 0x06000000, 16 zero words, 0x00000080.
- **Partial last word.** Word 0 = 0x11223344 with `is_last=1`, `byte_num=2`.
  - `out[575:544]`=0x11220600, `out[31:0]`=0x00000080.
- **Backpressure.** Keep `in_ready=1` with an incrementing word while `buffer_full`=1 for 5 cycles before `f_ack`.
  - No word is lost or duplicated: the next block starts with the word held at the `f_ack` cycle.
- **Reset mid-operation.** Assert `reset_n`=0 after 9 words, and again during PAD.
  - `out`=0 and `out_ready`=0 immediately (asynchronously).
  - A following message is padded correctly from slot 0.

Source files
------------

// File: rtl/sha3_block_padder.sv
`default_nettype none
// ============================================================================
// Module   : sha3_word_padder / sha3_block_padder
// Purpose  : sha3_word_padder builds the padded final message word.
//            sha3_block_padder assembles 576-bit SHA3-512 rate blocks
//            (18 x 32-bit big-endian words) and applies the SHA3 padding
//            (domain byte 0x06 after the message and 0x80 in the block's
//            last byte). Each finished block is held for the Keccak-f stage
//            until that stage acknowledges it.
// Ports (sha3_block_padder):
//   clk         in   1   rising-edge clock
//   reset_n     in   1   asynchronous active-low reset
//   in          in  32   message word, byte 0 in in[31:24]
//   in_ready    in   1   in is valid this cycle
//   is_last     in   1   this word is the final (possibly partial) word
//   byte_num    in   2   valid bytes in the final word (0..3)
//   buffer_full out  1   18 words buffered, upstream must hold its word
//   out         out 576  assembled block, first word in out[575:544]
//   out_ready   out  1   out holds a complete block (same as buffer_full)
//   f_ack       in   1   permutation stage has taken out
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Combinational final-word padder: keeps the first byte_num bytes of in,
// places 0x06 right after them, zero-fills the rest, and ORs in the 0x80
// block terminator when the word lands in the block's last slot.
// ----------------------------------------------------------------------------
module sha3_word_padder (
  input  logic [31:0] in,
  input  logic [1:0]  byte_num,
  input  logic        last_slot,
  output logic [31:0] out
);

  logic [31:0] w_keep_mask;
  logic [31:0] w_domain;

  always_comb begin
    w_keep_mask = 32'h0000_0000;
    w_domain    = 32'h0600_0000;
    case (byte_num)
      2'd0: begin
        w_keep_mask = 32'h0000_0000;
        w_domain    = 32'h0600_0000;
      end
      2'd1: begin
        w_keep_mask = 32'hFF00_0000;
        w_domain    = 32'h0006_0000;
      end
      2'd2: begin
        w_keep_mask = 32'hFFFF_0000;
        w_domain    = 32'h0000_0600;
      end
      default: begin
        w_keep_mask = 32'hFFFF_FF00;
        w_domain    = 32'h0000_0006;
      end
    endcase
  end

  assign out = (in & w_keep_mask) | w_domain | (last_slot ? 32'h0000_0080 : 32'h0000_0000);

endmodule

// ----------------------------------------------------------------------------
// Block assembler with ACCEPT / PAD / DONE sequencing.
// ----------------------------------------------------------------------------
module sha3_block_padder (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  in,
  input  logic         in_ready,
  input  logic         is_last,
  input  logic [1:0]   byte_num,
  output logic         buffer_full,
  output logic [575:0] out,
  output logic         out_ready,
  input  logic         f_ack
);

  localparam logic [1:0] c_ST_ACCEPT = 2'd0;
  localparam logic [1:0] c_ST_PAD    = 2'd1;
  localparam logic [1:0] c_ST_DONE   = 2'd2;

  localparam logic [4:0] c_LAST_SLOT = 5'd17;
  localparam logic [4:0] c_FULL_CNT  = 5'd18;

  logic [1:0]   r_state;
  logic [1:0]   w_next_state;
  logic [4:0]   r_cnt;
  logic [575:0] r_out;

  logic         w_full;
  logic         w_slot17;
  logic         w_wr_en;
  logic [31:0]  w_wr_data;
  logic [31:0]  w_padded_word;

  assign w_full   = (r_cnt == c_FULL_CNT);
  assign w_slot17 = (r_cnt == c_LAST_SLOT);

  sha3_word_padder u_word_padder (
    .in        (in),
    .byte_num  (byte_num),
    .last_slot (w_slot17),
    .out       (w_padded_word)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_ST_ACCEPT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic. DONE is terminal: only reset starts a new message.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_ACCEPT: begin
        if (in_ready && !w_full && is_last) begin
          w_next_state = w_slot17 ? c_ST_DONE : c_ST_PAD;
        end
      end
      c_ST_PAD: begin
        if (!w_full && w_slot17) begin
          w_next_state = c_ST_DONE;
        end
      end
      c_ST_DONE: begin
        w_next_state = c_ST_DONE;
      end
      default: begin
        w_next_state = c_ST_ACCEPT;
      end
    endcase
  end

  // Output logic: which word (if any) is shifted into the block this cycle.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_data = 32'h0000_0000;
    case (r_state)
      c_ST_ACCEPT: begin
        if (in_ready && !w_full) begin
          w_wr_en   = 1'b1;
          w_wr_data = is_last ? w_padded_word : in;
        end
      end
      c_ST_PAD: begin
        // PAD never sees a full buffer (the last word landed below slot 17),
        // but the guard keeps the write rule identical to ACCEPT.
        if (!w_full) begin
          w_wr_en   = 1'b1;
          w_wr_data = w_slot17 ? 32'h0000_0080 : 32'h0000_0000;
        end
      end
      default: begin
        w_wr_en   = 1'b0;
        w_wr_data = 32'h0000_0000;
      end
    endcase
  end

  // Word counter. A write and an ack cannot coincide: writes need !w_full
  // and the ack only counts when w_full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 5'd0;
    end else if (f_ack && w_full) begin
      r_cnt <= 5'd0;
    end else if (w_wr_en) begin
      r_cnt <= r_cnt + 5'd1;
    end
  end

  // Block shift register. Contents survive the ack; only reset clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= '0;
    end else if (w_wr_en) begin
      r_out <= {r_out[543:0], w_wr_data};
    end
  end

  assign out         = r_out;
  assign buffer_full = w_full;
  assign out_ready   = w_full;

endmodule

`default_nettype wire

// File: tb/tb_sha3_block_padder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha3_block_padder
// Purpose  : Self-checking bench for sha3_block_padder. A byte-level SHA3
//            padding model pushes expected blocks (and the cycle the final
//            block must appear) into a scoreboard as words are driven; a
//            monitor pops and compares whenever out_ready rises, then acks
//            after a per-test delay. A vector table covers the message
//            shapes; hand sequences cover asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha3_block_padder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  in;
  logic         in_ready;
  logic         is_last;
  logic [1:0]   byte_num;
  logic         buffer_full;
  logic [575:0] out;
  logic         out_ready;
  logic         f_ack;

  sha3_block_padder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in          (in),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .buffer_full (buffer_full),
    .out         (out),
    .out_ready   (out_ready),
    .f_ack       (f_ack)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [575:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [7:0]   mbytes[$];
  int           ack_delay   = 0;
  int           blocks_seen = 0;
  int           full_cyc    = 0;

  typedef struct {
    int          n_words;
    logic [31:0] fill;
    logic [31:0] inc;
    logic [31:0] last_w;
    logic [1:0]  bn;
    int          delay;
    int          exp_blocks;
    logic [31:0] exp_head;
    logic [31:0] exp_tail;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [575:0] act, input logic [575:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [575:0] bytes_to_block();
    logic [575:0] blk;
    blk = '0;
    for (int i = 0; i < 72; i++) blk[575 - 8*i -: 8] = mbytes[i];
    return blk;
  endfunction

  // Reference model: message bytes in, standard SHA3 byte padding out.
  task automatic model_word(input logic [31:0] w, input logic last, input logic [1:0] bn,
                            input int accept_cyc);
    int slot;
    if (!last) begin
      for (int b = 0; b < 4; b++) mbytes.push_back(w[31 - 8*b -: 8]);
      if (mbytes.size() == 72) begin
        exp_q.push_back(bytes_to_block());
        exp_cyc_q.push_back(-1);
        mbytes.delete();
      end
    end else begin
      slot = mbytes.size() / 4;
      for (int b = 0; b < int'(bn); b++) mbytes.push_back(w[31 - 8*b -: 8]);
      mbytes.push_back(8'h06);
      while (mbytes.size() < 72) mbytes.push_back(8'h00);
      mbytes[71] = mbytes[71] | 8'h80;
      exp_q.push_back(bytes_to_block());
      exp_cyc_q.push_back(accept_cyc + 17 - slot);
      mbytes.delete();
    end
  endtask

  // Monitor / acker.
  always @(negedge clk) begin
    if (!reset_n) begin
      full_cyc = 0;
      f_ack    = 1'b0;
    end else if (out_ready) begin
      if (full_cyc == 0) begin
        blocks_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_block actual=%h required=none", out);
        end else begin
          logic [575:0] eb;
          int           ec;
          eb = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("block_data", out, eb);
          if (ec >= 0) check("ready_latency_cycle", 576'(cyc), 576'(ec));
        end
      end
      f_ack = (full_cyc >= ack_delay);
      full_cyc++;
    end else begin
      full_cyc = 0;
      f_ack    = 1'b0;
    end
  end

  task automatic clear_model();
    exp_q.delete();
    exp_cyc_q.delete();
    mbytes.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_ready = 1'b0;
    is_last  = 1'b0;
    byte_num = 2'd0;
    in       = 32'h0;
    reset_n  = 1'b0;
    clear_model();
    #1;
    check("reset_out", out, '0);
    check("reset_out_ready", 576'(out_ready), 576'(0));
    check("reset_buffer_full", 576'(buffer_full), 576'(0));
    @(negedge clk);
    @(negedge clk);
    reset_n     = 1'b1;
    blocks_seen = 0;
  endtask

  // Present a word and hold it until the DUT can take it.
  task automatic send_word(input logic [31:0] w, input logic last, input logic [1:0] bn);
    int waited;
    waited = 0;
    forever begin
      @(negedge clk);
      in       = w;
      in_ready = 1'b1;
      is_last  = last;
      byte_num = bn;
      if (!buffer_full) break;
      waited++;
      if (waited > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=full required=not_full");
        return;
      end
    end
    model_word(w, last, bn, cyc + 1);
  endtask

  // Keep hammering garbage on in_ready; DONE/PAD must ignore it.
  task automatic idle_garbage(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in       = $urandom;
      in_ready = 1'b1;
      is_last  = 1'($urandom_range(0, 1));
      byte_num = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    in_ready = 1'b0;
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    do_reset();
    ack_delay = v.delay;
    for (int i = 0; i < v.n_words; i++) send_word(v.fill + v.inc * 32'(i), 1'b0, 2'd0);
    send_word(v.last_w, 1'b1, v.bn);
    idle_garbage(45);
    check($sformatf("v%0d_pending", idx), 576'(exp_q.size()), 576'(0));
    check($sformatf("v%0d_blocks", idx), 576'(blocks_seen), 576'(v.exp_blocks));
    check($sformatf("v%0d_head", idx), 576'(out[575:544]), 576'(v.exp_head));
    check($sformatf("v%0d_tail", idx), 576'(out[31:0]), 576'(v.exp_tail));
    check($sformatf("v%0d_done_idle", idx), 576'({out_ready, buffer_full}), 576'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b1;
    in       = 32'h0;
    in_ready = 1'b0;
    is_last  = 1'b0;
    byte_num = 2'd0;

    //          n   fill          inc           last_w        bn  dly blk head          tail
    vecs[0] = '{0,  32'h0,        32'h0,        32'h0,        2'd0, 0, 1, 32'h0600_0000, 32'h0000_0080};
    vecs[1] = '{17, 32'hAAAA_AAAA, 32'h0,       32'h1122_3344, 2'd3, 0, 1, 32'hAAAA_AAAA, 32'h1122_3386};
    vecs[2] = '{18, 32'h0102_0304, 32'h0101_0101, 32'hDEAD_BEEF, 2'd0, 0, 2, 32'h0600_0000, 32'h0000_0080};
    vecs[3] = '{0,  32'h0,        32'h0,        32'h1122_3344, 2'd2, 0, 1, 32'h1122_0600, 32'h0000_0080};
    vecs[4] = '{40, 32'h0000_1000, 32'h1,       32'h5566_7788, 2'd1, 5, 3, 32'h0000_1024, 32'h0000_0080};
    vecs[5] = '{5,  32'hC0C0_C0C0, 32'h0,       32'h1234_5678, 2'd1, 1, 1, 32'hC0C0_C0C0, 32'h0000_0080};
    vecs[6] = '{35, 32'h0,        32'h11,       32'hABCD_EF01, 2'd0, 2, 2, 32'h0000_0132, 32'h0600_0080};
    vecs[7] = '{0,  32'h0,        32'h0,        32'hCAFE_BABE, 2'd3, 3, 1, 32'hCAFE_BA06, 32'h0000_0080};

    for (int i = 0; i < 8; i++) run_vector(vecs[i], i);

    // Asynchronous reset after 9 words.
    do_reset();
    ack_delay = 0;
    for (int i = 0; i < 9; i++) send_word(32'h7700_0000 + 32'(i), 1'b0, 2'd0);
    @(negedge clk);
    in_ready = 1'b0;
    #2 reset_n = 1'b0;
    clear_model();
    #1;
    check("mid_block_reset_out", out, '0);
    check("mid_block_reset_ready", 576'(out_ready), 576'(0));
    @(negedge clk);
    reset_n     = 1'b1;
    blocks_seen = 0;
    send_word(32'h9988_7766, 1'b1, 2'd2);
    idle_garbage(30);
    check("post_reset_head", 576'(out[575:544]), 576'(32'h9988_0600));
    check("post_reset_blocks", 576'(blocks_seen), 576'(1));

    // Asynchronous reset while in PAD.
    do_reset();
    for (int i = 0; i < 3; i++) send_word(32'h5A5A_0000 + 32'(i), 1'b0, 2'd0);
    send_word(32'h0102_0304, 1'b1, 2'd1);
    @(negedge clk);
    in_ready = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    clear_model();
    #1;
    check("pad_reset_out", out, '0);
    check("pad_reset_ready", 576'(out_ready), 576'(0));
    @(negedge clk);
    reset_n     = 1'b1;
    blocks_seen = 0;
    repeat (25) @(negedge clk);
    check("pad_reset_no_block", 576'(blocks_seen), 576'(0));

    // Asynchronous reset while a full block is waiting for its ack.
    do_reset();
    ack_delay = 50;
    for (int i = 0; i < 18; i++) send_word(32'h3300_0000 + 32'(i), 1'b0, 2'd0);
    @(negedge clk);
    in_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("full_before_reset", 576'(out_ready), 576'(1));
    #2 reset_n = 1'b0;
    clear_model();
    #1;
    check("full_reset_ready", 576'({out_ready, buffer_full}), 576'(0));
    check("full_reset_out", out, '0);
    @(negedge clk);
    reset_n = 1'b1;
    run_vector(vecs[3], 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
